// File: rtl/onehot_dec_seq.sv
// Registered N-to-2^N one-hot decoder with load, rotate-up/down (wrap pulse) and hold.
// Q, IDX, VALID and WRAP all come straight from flops; no input reaches an output combinationally.
module onehot_dec_seq #(
    parameter int unsigned SEL_W   = 5,
    parameter int unsigned RST_IDX = 0
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     CLR,
    input  logic                     EN,
    input  logic [1:0]               MODE,
    input  logic [SEL_W-1:0]         SEL,
    output logic [(1<<SEL_W)-1:0]    Q,
    output logic [SEL_W-1:0]         IDX,
    output logic                     VALID,
    output logic                     WRAP
);

    localparam int unsigned OUT_W = 1 << SEL_W;

    localparam logic [SEL_W-1:0] RST_IDX_L = RST_IDX[SEL_W-1:0];

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_ACTIVE = 1'b1;

    localparam logic [1:0] MODE_HOLD   = 2'b00;
    localparam logic [1:0] MODE_LOAD   = 2'b01;
    localparam logic [1:0] MODE_ROT_UP = 2'b10;
    localparam logic [1:0] MODE_ROT_DN = 2'b11;

    logic [0:0]       state;
    logic [SEL_W-1:0] idx;
    logic [OUT_W-1:0] q;
    logic             wrap;

    function automatic logic [OUT_W-1:0] decode(input logic [SEL_W-1:0] s);
        logic [OUT_W-1:0] d;
        d    = '0;
        d[s] = 1'b1;
        return d;
    endfunction

    // Rotates act only while ACTIVE, so Q stays all-zero in IDLE without extra gating.
    always_ff @(posedge CLK) begin
        if (RST || CLR) begin
            state <= ST_IDLE;
            idx   <= RST_IDX_L;
            q     <= '0;
            wrap  <= 1'b0;
        end else begin
            wrap <= 1'b0;
            if (EN) begin
                case (MODE)
                    MODE_HOLD: ;
                    MODE_LOAD: begin
                        state <= ST_ACTIVE;
                        idx   <= SEL;
                        q     <= decode(SEL);
                    end
                    MODE_ROT_UP: begin
                        if (state == ST_ACTIVE) begin
                            idx  <= idx + 1'b1;
                            q    <= {q[OUT_W-2:0], q[OUT_W-1]};
                            wrap <= (idx == '1);
                        end
                    end
                    MODE_ROT_DN: begin
                        if (state == ST_ACTIVE) begin
                            idx  <= idx - 1'b1;
                            q    <= {q[0], q[OUT_W-1:1]};
                            wrap <= (idx == '0);
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign Q     = q;
    assign IDX   = idx;
    assign VALID = (state == ST_ACTIVE);
    assign WRAP  = wrap;

endmodule

// File: tb/tb_onehot_dec_seq.sv
// Scoreboard bench for onehot_dec_seq: a 5-bit and a 3-bit instance share one stimulus stream,
// an index/active model predicts each cycle, and a monitor compares outputs one cycle later.
module tb_onehot_dec_seq;

    logic        clk;
    logic        rst, clr, en;
    logic [1:0]  mode;
    logic [4:0]  sel;

    logic [31:0] q5;
    logic [4:0]  idx5;
    logic        valid5, wrap5;
    logic [7:0]  q3;
    logic [2:0]  idx3;
    logic        valid3, wrap3;

    onehot_dec_seq #(.SEL_W(5), .RST_IDX(0)) dut5 (
        .CLK(clk), .RST(rst), .CLR(clr), .EN(en), .MODE(mode), .SEL(sel),
        .Q(q5), .IDX(idx5), .VALID(valid5), .WRAP(wrap5)
    );

    onehot_dec_seq #(.SEL_W(3), .RST_IDX(5)) dut3 (
        .CLK(clk), .RST(rst), .CLR(clr), .EN(en), .MODE(mode), .SEL(sel[2:0]),
        .Q(q3), .IDX(idx3), .VALID(valid3), .WRAP(wrap3)
    );

    typedef struct {
        logic [31:0] q;
        logic [4:0]  idx;
        logic        valid;
        logic        wrap;
    } exp_t;

    exp_t sb5[$];
    exp_t sb3[$];

    int  checks  = 0;
    int  errors  = 0;
    bit  running = 1'b0;

    int  m_idx[2];
    bit  m_act[2];
    bit  m_wrap[2];
    int  m_n[2]    = '{32, 8};
    int  m_rsti[2] = '{0, 5};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
        end
    endfunction

    // Reference model: an integer index plus an active flag, updated from the sampled command.
    always @(posedge clk) begin
        if (running) begin
            for (int d = 0; d < 2; d++) begin
                exp_t e;
                int   n;
                n = m_n[d];
                m_wrap[d] = 1'b0;
                if (rst || clr) begin
                    m_act[d] = 1'b0;
                    m_idx[d] = m_rsti[d];
                end else if (en) begin
                    if (mode == 2'd1) begin
                        m_idx[d] = int'(sel) % n;
                        m_act[d] = 1'b1;
                    end else if (mode == 2'd2 && m_act[d]) begin
                        m_wrap[d] = (m_idx[d] == n - 1);
                        m_idx[d]  = (m_idx[d] + 1) % n;
                    end else if (mode == 2'd3 && m_act[d]) begin
                        m_wrap[d] = (m_idx[d] == 0);
                        m_idx[d]  = (m_idx[d] + n - 1) % n;
                    end
                end
                e.q     = m_act[d] ? (32'd1 << m_idx[d]) : 32'd0;
                e.idx   = 5'(m_idx[d]);
                e.valid = m_act[d];
                e.wrap  = m_wrap[d];
                if (d == 0) sb5.push_back(e);
                else        sb3.push_back(e);
            end
        end
    end

    always @(posedge clk) begin
        #1;
        if (running) begin
            if (sb5.size() == 0 || sb3.size() == 0) begin
                chk("scoreboard_empty", 32'd1, 32'd0);
            end else begin
                exp_t e5, e3;
                e5 = sb5.pop_front();
                e3 = sb3.pop_front();
                chk("q5",     q5,            e5.q);
                chk("idx5",   32'(idx5),     32'(e5.idx));
                chk("valid5", 32'(valid5),   32'(e5.valid));
                chk("wrap5",  32'(wrap5),    32'(e5.wrap));
                chk("q3",     32'(q3),       e3.q);
                chk("idx3",   32'(idx3),     32'(e3.idx));
                chk("valid3", 32'(valid3),   32'(e3.valid));
                chk("wrap3",  32'(wrap3),    32'(e3.wrap));
            end
        end
    end

    task automatic cmd(input bit r, input bit c, input bit e, input logic [1:0] m, input logic [4:0] s);
        @(negedge clk);
        rst = r; clr = c; en = e; mode = m; sel = s;
    endtask

    // Direct check of the 5-bit instance right after the command just issued is applied.
    task automatic expect5(input string name, input logic [31:0] xq, input logic [4:0] xi,
                           input bit xv, input bit xw);
        @(posedge clk);
        #2;
        chk({name, "_q"},     q5,          xq);
        chk({name, "_idx"},   32'(idx5),   32'(xi));
        chk({name, "_valid"}, 32'(valid5), 32'(xv));
        chk({name, "_wrap"},  32'(wrap5),  32'(xw));
    endtask

    logic [4:0]  sweep_sel[7] = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd7, 5'd31};
    logic [31:0] sweep_q[7]   = '{32'h1, 32'h2, 32'h4, 32'h8, 32'h10, 32'h80, 32'h8000_0000};

    initial begin
        rst = 1'b1; clr = 1'b0; en = 1'b0; mode = 2'd0; sel = '0;
        running = 1'b1;

        cmd(1, 0, 0, 2'd0, 5'd0);
        cmd(1, 0, 0, 2'd0, 5'd0);
        expect5("reset", 32'h0, 5'd0, 0, 0);

        for (int i = 0; i < 7; i++) begin
            cmd(0, 0, 1, 2'd1, sweep_sel[i]);
            expect5("load_sweep", sweep_q[i], sweep_sel[i], 1, 0);
        end

        cmd(0, 0, 1, 2'd1, 5'd30);
        cmd(0, 0, 1, 2'd2, 5'd0); expect5("rotup_a", 32'h8000_0000, 5'd31, 1, 0);
        cmd(0, 0, 1, 2'd2, 5'd0); expect5("rotup_b", 32'h1,         5'd0,  1, 1);
        cmd(0, 0, 1, 2'd2, 5'd0); expect5("rotup_c", 32'h2,         5'd1,  1, 0);

        cmd(0, 0, 1, 2'd1, 5'd1);
        cmd(0, 0, 1, 2'd3, 5'd0); expect5("rotdn_a", 32'h1,         5'd0,  1, 0);
        cmd(0, 0, 1, 2'd3, 5'd0); expect5("rotdn_b", 32'h8000_0000, 5'd31, 1, 1);
        cmd(0, 0, 1, 2'd0, 5'd0); expect5("hold",    32'h8000_0000, 5'd31, 1, 0);

        cmd(1, 0, 0, 2'd0, 5'd0);
        cmd(0, 0, 1, 2'd2, 5'd0); expect5("idle_rot", 32'h0, 5'd0, 0, 0);
        cmd(0, 0, 0, 2'd1, 5'd5); expect5("en_gate",  32'h0, 5'd0, 0, 0);

        cmd(0, 0, 1, 2'd1, 5'd9);
        cmd(0, 1, 1, 2'd1, 5'd3); expect5("clr_prec", 32'h0, 5'd0, 0, 0);
        cmd(0, 0, 1, 2'd1, 5'd9);
        cmd(1, 0, 1, 2'd2, 5'd0); expect5("rst_prec", 32'h0, 5'd0, 0, 0);

        cmd(0, 0, 1, 2'd1, 5'd7);
        cmd(0, 0, 1, 2'd2, 5'd0);
        @(posedge clk);
        #2;
        chk("w3_wrap_q",    32'(q3),    32'h01);
        chk("w3_wrap_flag", 32'(wrap3), 32'd1);

        for (int i = 0; i < 400; i++) begin
            int r;
            r = int'($urandom_range(99));
            cmd(r < 2, (r >= 2 && r < 5), ($urandom_range(9) < 8),
                2'($urandom_range(3)), 5'($urandom_range(31)));
        end

        cmd(0, 0, 0, 2'd0, 5'd0);
        @(negedge clk);
        @(negedge clk);
        running = 1'b0;
        chk("sb5_drained", 32'(sb5.size()), 32'd0);
        chk("sb3_drained", 32'(sb3.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
